bitsync_lock_ctrl: RTL

//  Sequencer and lock supervisor for the bit synchronizer. Holds the synchronizer in

---
 rtl/bitsync_lock_ctrl_pkg.sv | 20 ++
 rtl/bitsync_period_meter.sv | 67 ++++++
 rtl/bitsync_lock_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bitsync_lock_ctrl_pkg.sv
// Shared types and helpers for the bit-synchronizer lock supervisor.
// State encodings, counter width, saturating increment.
package bitsync_lock_ctrl_pkg;

  localparam int CW = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RST_HOLD = 2'd1,
    ST_ACQUIRE  = 2'd2,
    ST_LOCKED   = 2'd3
  } state_e;

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v
  );
    return (v == '1) ? v : v + CW'(1);
  endfunction

endpackage

// File: rtl/bitsync_period_meter.sv
// Bit_Sync rising-edge detector and period meter.
// Emits an eval strobe per measured edge or timeout, plus good flag.
module bitsync_period_meter
  import bitsync_lock_ctrl_pkg::*;
#(
  parameter int SYM_PERIOD = 32,
  parameter int PER_TOL    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  input  logic          i_bit_sync,
  output logic [CW-1:0] o_period,
  output logic          o_eval,
  output logic          o_good
);

  localparam logic [CW-1:0] TMO = CW'(2 * SYM_PERIOD - 1);
  localparam logic [CW-1:0] LO  = CW'(SYM_PERIOD - PER_TOL);
  localparam logic [CW-1:0] HI  = CW'(SYM_PERIOD + PER_TOL);

  logic          r_bs_q;
  logic          r_bs_qq;
  logic          r_armed;
  logic [CW-1:0] r_per_cnt;
  logic [CW-1:0] r_period;
  logic          w_edge;
  logic          w_tmo;
  logic          w_in;
  logic [CW-1:0] w_meas;

  assign w_edge = r_bs_q & ~r_bs_qq;
  // an edge on the timeout cycle wins
  assign w_tmo  = ~w_edge & (r_per_cnt == TMO);
  assign w_meas = sat_inc(r_per_cnt);
  assign w_in   = (w_meas >= LO) && (w_meas <= HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bs_q    <= 1'b0;
      r_bs_qq   <= 1'b0;
      r_armed   <= 1'b0;
      r_per_cnt <= '0;
      r_period  <= '0;
    end else begin
      r_bs_q  <= i_bit_sync;
      r_bs_qq <= r_bs_q;
      if (!i_run) begin
        r_per_cnt <= '0;
        r_armed   <= 1'b0;
      end else if (w_edge) begin
        r_per_cnt <= '0;
        r_armed   <= 1'b1;
        r_period  <= w_meas;
      end else if (w_tmo) begin
        r_per_cnt <= '0;
      end else begin
        r_per_cnt <= sat_inc(r_per_cnt);
      end
    end
  end

  assign o_period = r_period;
  assign o_eval   = i_run & ((w_edge & r_armed) | w_tmo);
  assign o_good   = w_edge & w_in;

endmodule

// File: rtl/bitsync_lock_ctrl.sv
// Reset sequencer and lock supervisor for the bit synchronizer.
// Optional BITSYNC_LOCK_STATS_EN adds relock_cnt and adj_last outputs.
module bitsync_lock_ctrl
  import bitsync_lock_ctrl_pkg::*;
#(
  parameter int SYM_PERIOD = 32,
  parameter int PER_TOL    = 2,
  parameter int RST_CYCLES = 16,
  parameter int LOCK_CNT   = 8,
  parameter int ACQ_MAX    = 64,
  parameter int UNLOCK_CNT = 4,
  parameter int ADJ_WINDOW = 16,
  parameter int ADJ_MAX    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       bit_sync,
  input  logic       pd_bef,
  input  logic       pd_aft,
  output logic       sync_rst,
  output logic       locked,
  output logic       lock_lost,
  output logic [1:0] state,
  output logic [7:0] period
`ifdef BITSYNC_LOCK_STATS_EN
  ,
  output logic [7:0] relock_cnt,
  output logic [7:0] adj_last
`endif
);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_N   = CW'(LOCK_CNT);
  localparam logic [CW-1:0] ACQ_N    = CW'(ACQ_MAX);
  localparam logic [CW-1:0] UNL_N    = CW'(UNLOCK_CNT);
  localparam logic [CW-1:0] WIN_N    = CW'(ADJ_WINDOW);
  localparam logic [CW-1:0] ADJ_N    = CW'(ADJ_MAX);

  state_e        r_state;
  state_e        w_nxt;
  logic          r_sync_rst;
  logic          r_locked;
  logic          r_lock_lost;
  logic [CW-1:0] r_rst_cnt;
  logic [CW-1:0] r_good_cnt;
  logic [CW-1:0] r_acq_cnt;
  logic [CW-1:0] r_bad_cnt;
  logic [CW-1:0] r_win_cnt;
  logic [CW-1:0] r_adj_cnt;
  logic [CW-1:0] w_rst_n;
  logic [CW-1:0] w_good_n;
  logic [CW-1:0] w_acq_n;
  logic [CW-1:0] w_bad_n;
  logic [CW-1:0] w_win_n;
  logic [CW-1:0] w_adj_n;
  logic [CW-1:0] w_adj_tot;
  logic          w_run;
  logic          w_eval;
  logic          w_good;
  logic          w_loss;
  logic          w_wclose;

  assign w_run = en &
    ((r_state == ST_ACQUIRE) | (r_state == ST_LOCKED));

  bitsync_period_meter #(
    .SYM_PERIOD (SYM_PERIOD),
    .PER_TOL    (PER_TOL)
  ) u_meter (
    .clk        (clk),
    .rst        (rst),
    .i_run      (w_run),
    .i_bit_sync (bit_sync),
    .o_period   (period),
    .o_eval     (w_eval),
    .o_good     (w_good)
  );

  always_comb begin
    w_nxt     = r_state;
    w_rst_n   = r_rst_cnt;
    w_good_n  = r_good_cnt;
    w_acq_n   = r_acq_cnt;
    w_bad_n   = r_bad_cnt;
    w_win_n   = r_win_cnt;
    w_adj_n   = r_adj_cnt;
    w_loss    = 1'b0;
    w_wclose  = 1'b0;
    w_adj_tot = (pd_bef | pd_aft) ? sat_inc(r_adj_cnt)
                                  : r_adj_cnt;
    unique case (r_state)
      ST_IDLE: w_nxt = ST_RST_HOLD;
      ST_RST_HOLD: begin
        if (r_rst_cnt == RST_LAST) w_nxt = ST_ACQUIRE;
        else w_rst_n = sat_inc(r_rst_cnt);
      end
      ST_ACQUIRE: begin
        if (w_eval) begin
          w_good_n = w_good ? sat_inc(r_good_cnt) : '0;
          w_acq_n  = sat_inc(r_acq_cnt);
          // lock wins over retry on the same evaluation
          if (w_good_n == LOCK_N) w_nxt = ST_LOCKED;
          else if (w_acq_n == ACQ_N) w_nxt = ST_RST_HOLD;
        end
      end
      ST_LOCKED: begin
        w_adj_n = w_adj_tot;
        if (w_eval) begin
          w_bad_n = w_good ? '0 : sat_inc(r_bad_cnt);
          w_win_n = sat_inc(r_win_cnt);
          if (w_win_n == WIN_N) begin
            w_wclose = 1'b1;
            w_win_n  = '0;
            w_adj_n  = '0;
          end
          if ((w_bad_n == UNL_N) ||
              (w_wclose && (w_adj_tot > ADJ_N))) begin
            w_nxt  = ST_RST_HOLD;
            w_loss = 1'b1;
          end
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
    // disable is a quiet exit: no loss pulse
    if (!en) begin
      w_nxt    = ST_IDLE;
      w_loss   = 1'b0;
      w_wclose = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sync_rst  <= 1'b1;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
      r_rst_cnt   <= '0;
      r_good_cnt  <= '0;
      r_acq_cnt   <= '0;
      r_bad_cnt   <= '0;
      r_win_cnt   <= '0;
      r_adj_cnt   <= '0;
    end else begin
      r_state     <= w_nxt;
      r_sync_rst  <= (w_nxt == ST_IDLE) ||
                     (w_nxt == ST_RST_HOLD);
      r_locked    <= (w_nxt == ST_LOCKED);
      r_lock_lost <= w_loss;
      r_rst_cnt   <= (w_nxt == ST_RST_HOLD) ? w_rst_n : '0;
      r_good_cnt  <= (w_nxt == ST_ACQUIRE) ? w_good_n : '0;
      r_acq_cnt   <= (w_nxt == ST_ACQUIRE) ? w_acq_n : '0;
      r_bad_cnt   <= (w_nxt == ST_LOCKED) ? w_bad_n : '0;
      r_win_cnt   <= (w_nxt == ST_LOCKED) ? w_win_n : '0;
      r_adj_cnt   <= (w_nxt == ST_LOCKED) ? w_adj_n : '0;
    end
  end

  assign sync_rst  = r_sync_rst;
  assign locked    = r_locked;
  assign lock_lost = r_lock_lost;
  assign state     = r_state;

`ifdef BITSYNC_LOCK_STATS_EN
  logic [CW-1:0] r_relock;
  logic [CW-1:0] r_adj_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_relock   <= '0;
      r_adj_last <= '0;
    end else begin
      if (w_loss) r_relock <= sat_inc(r_relock);
      if (w_wclose) r_adj_last <= w_adj_tot;
    end
  end

  assign relock_cnt = r_relock;
  assign adj_last   = r_adj_last;
`endif

endmodule
